// File: rtl/mat_result_streamer_if.sv
// Output stream bundle of the matrix result streamer: one signed element per
// beat with its row/column coordinates and an end-of-matrix marker.
interface mat_result_streamer_if #(
    parameter int W_OUT = 32,
    parameter int N     = 8
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic signed [W_OUT-1:0] m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_last;
    logic [RW-1:0]           m_row;
    logic [RW-1:0]           m_col;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        output m_row,
        output m_col,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        input  m_row,
        input  m_col,
        output m_ready
    );
endinterface

// File: rtl/mat_result_streamer.sv
// Captures a complete N x N result matrix on a one-cycle valid_in pulse and
// streams it out element by element in row-major order over a valid/ready
// handshake. Matrices arriving while a stream is in progress are discarded
// and counted in a saturating drop counter.
module mat_result_streamer #(
    parameter int W_OUT = 32,
    parameter int N     = 8,
    parameter int CW    = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          valid_in,
    input  logic signed [N*N*W_OUT-1:0]   result,
    output logic                          in_ready,
    mat_result_streamer_if.master         m_axis,
    output logic [CW-1:0]                 drop_count
);
    localparam int NE = N * N;
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;
    localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);
    localparam logic [CW-1:0] DROP_MAX = '1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                  r_state;
    logic signed [W_OUT-1:0] r_buf [NE];
    logic signed [W_OUT-1:0] r_m_data;
    logic                    r_in_ready;
    logic                    r_m_valid;
    logic                    r_m_last;
    logic [RW-1:0]           r_row;
    logic [RW-1:0]           r_col;
    logic [CW-1:0]           r_drop;

    logic                    w_capture;
    logic                    w_xfer;
    logic [RW-1:0]           w_next_row;
    logic [RW-1:0]           w_next_col;
    logic [IW-1:0]           w_next_idx;

    assign w_capture = (r_state == IDLE) && valid_in;
    assign w_xfer    = r_m_valid && m_axis.m_ready;

    // Row-major successor of the element currently on the output.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_next_col = r_col + 1'b1;
        w_next_row = r_row;
        if (r_col == LAST_IDX) begin
            w_next_col = '0;
            w_next_row = r_row + 1'b1;
        end
        w_next_idx = IW'(w_next_row) * IW'(N) + IW'(w_next_col);
    end

    // Matrix buffer: loaded only on the capture edge, later bus changes are ignored.
    // NOTE: the buffer has no reset; its contents only reach m_data through r_m_data, which is cleared whenever m_valid is low.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < NE; k++) begin
                r_buf[k] <= result[k*W_OUT +: W_OUT];
            end
        end
    end

    // Control FSM with registered handshake, data and coordinate outputs.
    always_ff @(posedge clk or posedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
        if (resetn) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_m_data   <= '0;
            r_row      <= '0;
            r_col      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        r_state    <= STREAM;
                        r_in_ready <= 1'b0;
                        r_m_valid  <= 1'b1;
                        r_m_data   <= result[0 +: W_OUT];
                        r_row      <= '0;
                        r_col      <= '0;
                        r_m_last   <= (NE == 1);
                    end
                end
                STREAM: begin
                    if (w_xfer) begin
                        if (r_m_last) begin
                            r_state    <= IDLE;
                            r_in_ready <= 1'b1;
                            r_m_valid  <= 1'b0;
                            r_m_last   <= 1'b0;
                            r_m_data   <= '0;
                            r_row      <= '0;
                            r_col      <= '0;
                        end else begin
                            r_row    <= w_next_row;
                            r_col    <= w_next_col;
                            r_m_data <= r_buf[w_next_idx];
                            r_m_last <= (w_next_row == LAST_IDX) && (w_next_col == LAST_IDX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Saturating count of matrices offered while busy.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_drop <= '0;
        end else if (valid_in && !r_in_ready && (r_drop != DROP_MAX)) begin
            r_drop <= r_drop + 1'b1;
        end
    end

    assign in_ready       = r_in_ready;
    assign drop_count     = r_drop;
    assign m_axis.m_data  = r_m_data;
    assign m_axis.m_valid = r_m_valid;
    assign m_axis.m_last  = r_m_last;
    assign m_axis.m_row   = r_row;
    assign m_axis.m_col   = r_col;
endmodule

// File: doc/mat_result_streamer.md
MAT_RESULT_STREAMER -- requirements
Module: mat_result_streamer

Interface
REQ-001 SHALL have parameter W_OUT, default 32, meaning width of one result element in bits (signed).
REQ-002 SHALL have parameter N, default 8, meaning matrix dimension; one matrix is N*N elements.
REQ-003 SHALL have parameter CW, default 8, meaning drop-counter width.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-high reset (1 = in reset).
REQ-006 SHALL have port valid_in  input  1  one-cycle pulse marking a valid result matrix.
REQ-007 SHALL have port result  input  N*N*W_OUT  signed flat matrix; element (r,c) at bits [(r*N+c)*W_OUT +: W_OUT].
REQ-008 SHALL have port in_ready  output  1  high when a new matrix can be captured.
REQ-009 SHALL have port m_data  output  W_OUT  signed streamed element.
REQ-010 SHALL have port m_valid  output  1  m_data valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts the element.
REQ-012 SHALL have port m_last  output  1  marks element (N-1,N-1).
REQ-013 SHALL have port m_row  output  clog2(N) (min 1)  row index of m_data.
REQ-014 SHALL have port m_col  output  clog2(N) (min 1)  column index of m_data.
REQ-015 SHALL have port drop_count  output  CW  number of matrices discarded because in_ready was low.

Function
REQ-016 SHALL implement two states: IDLE and STREAM.
REQ-017 in_ready SHALL be 1 exactly when state is IDLE (registered, no combinational path from m_ready or valid_in).
REQ-018 In IDLE, valid_in=1 SHALL capture the whole result into an internal buffer, set row=col=0, and enter STREAM on the same edge.
REQ-019 m_valid SHALL be 1 exactly in STREAM; the first element appears the cycle after capture (latency 1).
REQ-020 m_data SHALL equal buffered element (m_row,m_col) while m_valid=1, and 0 while m_valid=0.
REQ-021 A transfer SHALL occur on a rising edge with m_valid=1 and m_ready=1; m_data, m_row, m_col and m_last SHALL remain stable while m_valid=1 and m_ready=0.
REQ-022 Elements SHALL be sent row-major: col increments per transfer; at col=N-1, col wraps to 0 and row increments.
REQ-023 m_last SHALL be 1 only when m_valid=1, m_row=N-1 and m_col=N-1.
REQ-024 A transfer with m_last=1 SHALL return to IDLE, with m_valid=0 and in_ready=1 on the next cycle; row/col reset to 0.
REQ-025 valid_in=1 while in_ready=0 (including the cycle of the final transfer) SHALL NOT disturb the buffer or stream, and SHALL increment drop_count.
REQ-026 drop_count SHALL saturate at 2^CW-1 and never wrap.
REQ-027 With m_ready held at 1, one matrix SHALL occupy N*N+1 cycles from capture to in_ready=1; back-to-back matrices SHALL be accepted at that rate.
REQ-028 The result bus SHALL be sampled only on the capture edge; later changes on it SHALL NOT affect streamed data.

Reset
REQ-029 While resetn=1, asynchronously: state=IDLE, in_ready=1, m_valid=0, m_last=0, m_data=0, m_row=0, m_col=0, drop_count=0.
REQ-030 Reset during STREAM SHALL abandon the matrix; no further elements of that matrix SHALL be emitted after release.
REQ-031 The data buffer does not require reset; it SHALL never be visible on m_data while m_valid=0.

Verification
REQ-032 N=2, W_OUT=32, result elements {0:1, 1:-2, 2:3, 3:-4}, valid_in pulse, m_ready=1 -> m_data 1,-2,3,-4 on cycles t+1..t+4, (row,col) (0,0),(0,1),(1,0),(1,1), m_last only on the 4th, in_ready=1 at t+5.
REQ-033 Same matrix, m_ready toggling 1,0,0,1,... -> identical element order, outputs stable during stalls, no element duplicated or skipped.
REQ-034 valid_in pulses at t+2 and t+4 during streaming (the second coinciding with the final transfer) -> stream unaffected, drop_count=2.
REQ-035 CW=2, 5 dropped pulses -> drop_count saturates at 3.
REQ-036 resetn=1 asserted mid-stream after 2 transfers -> all outputs immediately at reset values; a new valid_in after release streams the new matrix from element (0,0).
REQ-037 N=8 default, random signed elements, random m_ready, 20 consecutive matrices -> scoreboard matches all 64 elements per matrix in row-major order.
